// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: shift-op encoding used by the pipelined barrel shifter.
package kgp_alu_pkg;

    typedef logic [1:0] shop_t;

    localparam shop_t SHOP_SRL = 2'b00;
    localparam shop_t SHOP_SRA = 2'b01;
    localparam shop_t SHOP_SLL = 2'b10;
    localparam shop_t SHOP_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One registered log2 stage of the barrel shifter: shifts by 2^K when shamt bit K is set.
// Rotate support is built only when BARREL_SHIFT_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module shift_stage
    import kgp_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3,
    parameter int unsigned K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  shop_t            op_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output shop_t            op_o,
    output logic [SHW-1:0]   shamt_o,
    output logic             carry_o
);

    localparam int unsigned Amt = 1 << K;

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    shop_t            op_d, op_q;
    logic [SHW-1:0]   shamt_d, shamt_q;
    logic             carry_d, carry_q;

    // An inactive stage passes data and the running carry unchanged, so the carry
    // left at the output is the one produced by the last stage that actually shifted.
    always_comb begin
        valid_d = valid_i;
        op_d    = op_i;
        shamt_d = shamt_i;
        data_d  = data_i;
        carry_d = carry_i;
        if (shamt_i[K]) begin
            unique case (op_i)
                SHOP_SRA: begin
                    data_d  = $signed(data_i) >>> Amt;
                    carry_d = data_i[Amt-1];
                end
                SHOP_SLL: begin
                    data_d  = data_i << Amt;
                    carry_d = data_i[WIDTH-Amt];
                end
`ifdef BARREL_SHIFT_ROTATE_EN
                SHOP_ROR: begin
                    data_d  = (data_i >> Amt) | (data_i << (WIDTH - Amt));
                    carry_d = data_d[WIDTH-1];
                end
`endif
                default: begin
                    data_d  = data_i >> Amt;
                    carry_d = data_i[Amt-1];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= SHOP_SRL;
            shamt_q <= '0;
            carry_q <= 1'b0;
        end else if (advance_i) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign shamt_o = shamt_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter (SRL/SRA/SLL/ROR), one log2 stage per cycle, global stall.
// BARREL_SHIFT_ROTATE_EN enables real rotate for op 11; without it op 11 executes as SRL.
module barrel_shifter_pipe
    import kgp_alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry,
    output logic             out_zero
);

    logic             valid_s [SHW+1];
    logic [WIDTH-1:0] data_s  [SHW+1];
    shop_t            op_s    [SHW+1];
    logic [SHW-1:0]   shamt_s [SHW+1];
    logic             carry_s [SHW+1];
    logic             advance;

    // A stalled result blocks every stage; an empty last stage lets the pipe move.
    assign advance  = out_ready || !valid_s[SHW];
    assign in_ready = advance;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_a;
    assign op_s[0]    = in_op;
    assign shamt_s[0] = in_shamt;
    assign carry_s[0] = 1'b0;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH(WIDTH),
            .SHW  (SHW),
            .K    (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .advance_i(advance),
            .valid_i  (valid_s[k]),
            .data_i   (data_s[k]),
            .op_i     (op_s[k]),
            .shamt_i  (shamt_s[k]),
            .carry_i  (carry_s[k]),
            .valid_o  (valid_s[k+1]),
            .data_o   (data_s[k+1]),
            .op_o     (op_s[k+1]),
            .shamt_o  (shamt_s[k+1]),
            .carry_o  (carry_s[k+1])
        );
    end

    logic unused_tail;
    assign unused_tail = ^{op_s[SHW], shamt_s[SHW]};

    assign out_valid = valid_s[SHW];
    assign out_y     = data_s[SHW];
    assign out_carry = carry_s[SHW];
    assign out_zero  = (data_s[SHW] == '0);

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter for the KGP ALU datapath. It generalises the 8-bit combinational logical-right shifter to WIDTH bits and four operations: logical right, arithmetic right, logical left and rotate right. One log2 shift stage is registered per pipeline stage, and a valid/ready handshake with global stall carries operations through. It sits between the ALU operand latch and the result writeback mux.

## Interface
- WIDTH, default 8: data width; power of two, 4..64.
- SHW, derived localparam = $clog2(WIDTH): shift-amount width and number of pipeline stages.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  00 SRL, 01 SRA, 10 SLL, 11 ROR.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_y  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out; see Operation.
- out_zero  output  1  out_y == 0.

## Operation
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Stage k (k = 0..SHW-1) shifts by 2^k when shamt[k] = 1, otherwise passes the value through. Each stage carries op, the remaining shamt bits, valid, and a running carry.
- SRL: fill with zeros. SRA: fill with in_a[WIDTH-1]. SLL: fill with zeros from bit 0. ROR: bits leaving bit 0 re-enter at bit WIDTH-1.
- out_carry:
  - SRL/SRA: last bit shifted out of bit 0.
  - SLL: last bit shifted out of bit WIDTH-1.
  - ROR: out_y[WIDTH-1].
  - shamt = 0: 0 for all ops.
- out_zero is computed in the final stage from the registered result.
- Global stall: advance = out_ready || !out_valid. When advance = 1, every stage register loads from its predecessor, and stage 0 loads the input (valid = in_valid). in_ready = advance.
- Bubbles are not collapsed. An empty last stage does enable advance, which lets the whole pipeline move.
- Operations complete in order. No reordering and no drops.

## Timing
- Latency is SHW cycles from acceptance to out_valid with no stall (WIDTH = 8: 3 cycles).
- Throughput is one operation per cycle while out_ready = 1.
- While out_valid && !out_ready, out_y, out_carry and out_zero hold stable, and in_ready = 0.
- in_ready is combinational from out_ready and out_valid only. There is no other input-to-output combinational path.
- Reset values:
  - All stage valid bits are 0, so out_valid = 0 and in_ready = 1 during and after reset.
  - out_y = 0, out_carry = 0 and out_zero = 1, since the data registers are cleared.
- Reset mid-operation discards every in-flight operation. There is no output in the cycle after reset deasserts.
- Simultaneous acceptance and delivery in the same cycle is legal and required for full throughput.

## Configuration
- BARREL_SHIFT_ROTATE_EN defined: op 11 performs ROR as above.
- BARREL_SHIFT_ROTATE_EN undefined:
  - Rotate wrap logic is not built.
  - op 11 executes as SRL (zero fill, SRL carry rule).
  - Everything else is identical, including latency and handshake.

## Structure
- Shared package kgp_alu_pkg holds:
  - the op encoding constants SHOP_SRL = 2'b00, SHOP_SRA = 2'b01, SHOP_SLL = 2'b10, SHOP_ROR = 2'b11;
  - a 2-bit shift-op typedef.
- One natural sub-module, shift_stage: a single registered stage parametrised by WIDTH and stage index k. It takes data, op, shamt bit k, carry and valid, plus an advance enable. barrel_shifter_pipe instantiates SHW of them in a generate loop.

## Test plan
- WIDTH = 8, SRL, a = 8'hB4, shamt = 3, out_ready = 1 → after 3 cycles out_y = 8'h16, out_carry = 1, out_zero = 0.
- SRA, a = 8'h80, shamt = 7 → out_y = 8'hFF, out_carry = 0. SLL, a = 8'h81, shamt = 1 → out_y = 8'h02, out_carry = 1.
- ROR, a = 8'h01, shamt = 1:
  - with BARREL_SHIFT_ROTATE_EN, out_y = 8'h80 and out_carry = 1;
  - without it, out_y = 8'h00, out_carry = 1 and out_zero = 1.
- Back-to-back stream of 8 ops with out_ready held low at cycles 5–7 → in_ready = 0 in those cycles, outputs hold stable, all 8 results arrive in order with no loss or duplication.
- shamt = 0 on all four ops with a = 8'h5A → out_y = 8'h5A and out_carry = 0.
- rst asserted for 1 cycle with 3 ops in flight → out_valid = 0 for the next 3 cycles, in_ready = 1 immediately after reset; repeat at WIDTH = 32 with SRA, a = 32'h8000_0000, shamt = 31 → out_y = 32'hFFFF_FFFF, with latency 5.
